issue_scoreboard: RTL

- Single-entry issue stage between decode and the execution units (ALU, MUL/DIV, FPU, LSU).
- Holds one fetched instruction_t word and tracks pending writes to the 32 integer and 32 FP registers in busy bitmaps.
- Stalls on RAW/WAW hazards, routes the instruction to its unit with a valid/ready handshake, and clears busy bits on writeback.

---
 rtl/issue_scoreboard_if.sv | 35 +++
 rtl/issue_scoreboard.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard_if.sv
// Decode-side, issue-side and writeback signals of the issue scoreboard.
// The slave modport is the scoreboard's view; master is the surrounding pipeline.
interface issue_scoreboard_if #(
  parameter int N_UNITS = 4
);
  logic [31:0]        instr_i;
  logic               instr_valid_i;
  logic               instr_ready_o;
  logic               flush_i;
  logic               issue_valid_o;
  logic [31:0]        issue_instr_o;
  logic [1:0]         issue_unit_o;
  logic               issue_illegal_o;
  logic [N_UNITS-1:0] unit_ready_i;
  logic               int_wb_valid_i;
  logic [4:0]         int_wb_rd_i;
  logic               fp_wb_valid_i;
  logic [4:0]         fp_wb_rd_i;
  logic [31:0]        busy_int_o;
  logic [31:0]        busy_fp_o;

  modport slave (
    input  instr_i, instr_valid_i, flush_i, unit_ready_i,
           int_wb_valid_i, int_wb_rd_i, fp_wb_valid_i, fp_wb_rd_i,
    output instr_ready_o, issue_valid_o, issue_instr_o, issue_unit_o,
           issue_illegal_o, busy_int_o, busy_fp_o
  );

  modport master (
    output instr_i, instr_valid_i, flush_i, unit_ready_i,
           int_wb_valid_i, int_wb_rd_i, fp_wb_valid_i, fp_wb_rd_i,
    input  instr_ready_o, issue_valid_o, issue_instr_o, issue_unit_o,
           issue_illegal_o, busy_int_o, busy_fp_o
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Single-entry issue stage: holds one instruction, tracks pending int/fp register
// writes in busy bitmaps, stalls on RAW/WAW hazards and routes to an execution unit.
module issue_scoreboard #(
  parameter int N_UNITS = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  issue_scoreboard_if.slave bus
);

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_FLOAD  = 7'b0000111,
    OP_FENCE  = 7'b0001111,
    OP_ALU_I  = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_FSTORE = 7'b0100111,
    OP_REG    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_FMADD  = 7'b1000011,
    OP_FMSUB  = 7'b1000111,
    OP_FNMSUB = 7'b1001011,
    OP_FNMADD = 7'b1001111,
    OP_F_OPS  = 7'b1010011,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_ECSR   = 7'b1110011
  } opcode_e;

  localparam logic [6:0] F7_M       = 7'b0000001;
  localparam logic [6:0] F7_FCVTW   = 7'b1100000;
  localparam logic [6:0] F7_FMV_CLS = 7'b1110000;
  localparam logic [6:0] F7_FCMP    = 7'b1010000;
  localparam logic [6:0] F7_FCVTS   = 7'b1101000;
  localparam logic [6:0] F7_FMVWX   = 7'b1111000;
  localparam logic [6:0] F7_FSQRT   = 7'b0101100;

  localparam logic [1:0] U_ALU    = 2'd0;
  localparam logic [1:0] U_MULDIV = 2'd1;
  localparam logic [1:0] U_FPU    = 2'd2;
  localparam logic [1:0] U_LSU    = 2'd3;

  logic               hold_valid_q, hold_valid_d;
  logic [31:0]        hold_instr_q, hold_instr_d;
  logic [31:0]        busy_int_q, busy_int_d;
  logic [31:0]        busy_fp_q, busy_fp_d;

  opcode_e            op_s;
  logic [4:0]         rd_s, rs1_s, rs2_s, rs3_s;
  logic [6:0]         funct7_s;
  logic               r1_int_s, r2_int_s, r1_fp_s, r2_fp_s, r3_fp_s;
  logic               wr_int_s, wr_fp_s, serial_s, illegal_s;
  logic [1:0]         unit_s;
  logic [31:0]        int_clr_s, fp_clr_s, int_set_s, fp_set_s;
  logic [31:0]        int_post_s, fp_post_s;
  logic               hazard_s, issue_valid_s, fire_s, accept_s, ready_s;
  logic [N_UNITS-1:0] unit_ready_s;

  assign op_s         = opcode_e'(hold_instr_q[6:0]);
  assign rd_s         = hold_instr_q[11:7];
  assign rs1_s        = hold_instr_q[19:15];
  assign rs2_s        = hold_instr_q[24:20];
  assign rs3_s        = hold_instr_q[31:27];
  assign funct7_s     = hold_instr_q[31:25];
  assign unit_ready_s = bus.unit_ready_i;

  // Decode the held instruction into register usage, serialisation and target unit.
  always_comb begin
    r1_int_s  = 1'b0;
    r2_int_s  = 1'b0;
    r1_fp_s   = 1'b0;
    r2_fp_s   = 1'b0;
    r3_fp_s   = 1'b0;
    wr_int_s  = 1'b0;
    wr_fp_s   = 1'b0;
    serial_s  = 1'b0;
    illegal_s = 1'b0;
    unit_s    = U_ALU;
    case (op_s)
      OP_LUI, OP_AUIPC, OP_JAL: wr_int_s = 1'b1;
      OP_JALR, OP_ALU_I: begin
        r1_int_s = 1'b1;
        wr_int_s = 1'b1;
      end
      OP_LOAD: begin
        r1_int_s = 1'b1;
        wr_int_s = 1'b1;
        unit_s   = U_LSU;
      end
      OP_BRANCH: begin
        r1_int_s = 1'b1;
        r2_int_s = 1'b1;
      end
      OP_STORE: begin
        r1_int_s = 1'b1;
        r2_int_s = 1'b1;
        unit_s   = U_LSU;
      end
      OP_REG: begin
        r1_int_s = 1'b1;
        r2_int_s = 1'b1;
        wr_int_s = 1'b1;
        unit_s   = (funct7_s == F7_M) ? U_MULDIV : U_ALU;
      end
      OP_FLOAD: begin
        r1_int_s = 1'b1;
        wr_fp_s  = 1'b1;
        unit_s   = U_LSU;
      end
      OP_FSTORE: begin
        r1_int_s = 1'b1;
        r2_fp_s  = 1'b1;
        unit_s   = U_LSU;
      end
      OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD: begin
        r1_fp_s = 1'b1;
        r2_fp_s = 1'b1;
        r3_fp_s = 1'b1;
        wr_fp_s = 1'b1;
        unit_s  = U_FPU;
      end
      OP_F_OPS: begin
        unit_s = U_FPU;
        case (funct7_s)
          F7_FCVTW, F7_FMV_CLS: begin
            r1_fp_s  = 1'b1;
            wr_int_s = 1'b1;
          end
          F7_FCMP: begin
            r1_fp_s  = 1'b1;
            r2_fp_s  = 1'b1;
            wr_int_s = 1'b1;
          end
          F7_FCVTS, F7_FMVWX: begin
            r1_int_s = 1'b1;
            wr_fp_s  = 1'b1;
          end
          F7_FSQRT: begin
            r1_fp_s = 1'b1;
            wr_fp_s = 1'b1;
          end
          default: begin
            r1_fp_s = 1'b1;
            r2_fp_s = 1'b1;
            wr_fp_s = 1'b1;
          end
        endcase
      end
      OP_FENCE: begin
        r1_int_s = 1'b1;
        serial_s = 1'b1;
      end
      OP_ECSR: begin
        r1_int_s = 1'b1;
        wr_int_s = 1'b1;
        serial_s = 1'b1;
      end
      default: illegal_s = 1'b1;
    endcase
  end

  // Writeback clears and issue sets; the hazard check sees post-writeback busy.
  always_comb begin
    int_clr_s = 32'd0;
    fp_clr_s  = 32'd0;
    if (bus.int_wb_valid_i) begin
      int_clr_s[bus.int_wb_rd_i] = 1'b1;
    end else begin
      int_clr_s = 32'd0;
    end
    if (bus.fp_wb_valid_i) begin
      fp_clr_s[bus.fp_wb_rd_i] = 1'b1;
    end else begin
      fp_clr_s = 32'd0;
    end
    int_post_s = busy_int_q & ~int_clr_s;
    fp_post_s  = busy_fp_q & ~fp_clr_s;
    int_post_s[0] = 1'b0;
  end

  // Hazard detection and the valid/ready handshakes.
  always_comb begin
    hazard_s = (r1_int_s && int_post_s[rs1_s]) ||
               (r2_int_s && int_post_s[rs2_s]) ||
               (r1_fp_s  && fp_post_s[rs1_s])  ||
               (r2_fp_s  && fp_post_s[rs2_s])  ||
               (r3_fp_s  && fp_post_s[rs3_s])  ||
               (wr_int_s && int_post_s[rd_s])  ||
               (wr_fp_s  && fp_post_s[rd_s])   ||
               (serial_s && ((|int_post_s) || (|fp_post_s)));
    issue_valid_s = !rst_i && hold_valid_q && !hazard_s && !bus.flush_i;
    fire_s        = issue_valid_s && unit_ready_s[unit_s];
    ready_s       = !rst_i && !bus.flush_i && (!hold_valid_q || fire_s);
    accept_s      = ready_s && bus.instr_valid_i;
  end

  // Next state for the hold register and both busy bitmaps.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    int_set_s    = 32'd0;
    fp_set_s     = 32'd0;
    if (bus.flush_i) begin
      hold_valid_d = 1'b0;
    end else if (accept_s) begin
      hold_valid_d = 1'b1;
      hold_instr_d = bus.instr_i;
    end else if (fire_s) begin
      hold_valid_d = 1'b0;
    end else begin
      hold_valid_d = hold_valid_q;
    end
    if (fire_s && wr_int_s) begin
      int_set_s[rd_s] = 1'b1;
    end else begin
      int_set_s = 32'd0;
    end
    if (fire_s && wr_fp_s) begin
      fp_set_s[rd_s] = 1'b1;
    end else begin
      fp_set_s = 32'd0;
    end
    // Set is applied after clear so an issuing rd wins over a same-cycle writeback.
    busy_int_d    = int_post_s | int_set_s;
    busy_int_d[0] = 1'b0;
    busy_fp_d     = fp_post_s | fp_set_s;
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_valid_q <= 1'b0;
      hold_instr_q <= 32'd0;
      busy_int_q   <= 32'd0;
      busy_fp_q    <= 32'd0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      busy_int_q   <= busy_int_d;
      busy_fp_q    <= busy_fp_d;
    end
  end

  assign bus.instr_ready_o   = ready_s;
  assign bus.issue_valid_o   = issue_valid_s;
  assign bus.issue_instr_o   = hold_valid_q ? hold_instr_q : 32'd0;
  assign bus.issue_unit_o    = hold_valid_q ? unit_s : 2'd0;
  assign bus.issue_illegal_o = hold_valid_q && illegal_s;
  assign bus.busy_int_o      = busy_int_q;
  assign bus.busy_fp_o       = busy_fp_q;

endmodule
